// File: rtl/direct_mapped_icache.sv
// Direct-mapped, read-only instruction cache: 64-byte lines, 8 x 64-bit beats,
// whole-line refill from Sysbus on a miss, then in-order streaming to the processor.
module direct_mapped_icache #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int NUM_SETS       = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      p_bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] p_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  p_bus_reqtag,
    output logic                      p_bus_reqack,
    output logic                      p_bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] p_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  p_bus_resptag,
    input  logic                      p_bus_respack,
    output logic                      m_bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
    input  logic                      m_bus_reqack,
    input  logic                      m_bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag,
    output logic                      m_bus_respack
);

    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int LINE_W = BUS_DATA_WIDTH - 6;
    localparam int LTAG_W = LINE_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_FILL,
        RESPOND
    } state_t;

    state_t                     state_q, state_d;
    logic [2:0]                 beat_q, beat_d;
    logic [LINE_W-1:0]          line_q, line_d;
    logic [BUS_TAG_WIDTH-1:0]   rtag_q, rtag_d;
    logic [NUM_SETS-1:0]        valid_q, valid_d;

    logic [LTAG_W-1:0]          tag_mem  [NUM_SETS];
    logic [BUS_DATA_WIDTH-1:0]  data_mem [NUM_SETS*8];

    logic [IDX_W-1:0]           idx;
    logic [LTAG_W-1:0]          ltag;
    logic                       hit;
    logic                       fill_we;
    logic                       tag_we;
    logic                       unused_inputs;

    assign idx  = line_q[IDX_W-1:0];
    assign ltag = line_q[LINE_W-1:IDX_W];
    assign hit  = valid_q[idx] && (tag_mem[idx] == ltag);

    // Byte offset is irrelevant (whole lines are returned) and memory tags are not checked.
    assign unused_inputs = ^{p_bus_req[5:0], m_bus_resptag};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= 3'd0;
            line_q  <= '0;
            rtag_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            rtag_q  <= rtag_d;
            valid_q <= valid_d;
        end
    end

    // Storage arrays carry no reset; only the valid bits decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[{idx, beat_q}] <= m_bus_resp;
        end
        if (tag_we) begin
            tag_mem[idx] <= ltag;
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        line_d        = line_q;
        rtag_d        = rtag_q;
        valid_d       = valid_q;
        fill_we       = 1'b0;
        tag_we        = 1'b0;
        p_bus_reqack  = 1'b0;
        p_bus_respcyc = 1'b0;
        p_bus_resp    = '0;
        p_bus_resptag = '0;
        m_bus_reqcyc  = 1'b0;
        m_bus_req     = '0;
        m_bus_reqtag  = '0;
        m_bus_respack = 1'b0;

        case (state_q)
            IDLE: begin
                if (reset && p_bus_reqcyc && p_bus_reqtag[BUS_TAG_WIDTH-1]) begin
                    p_bus_reqack = 1'b1;
                    line_d       = p_bus_req[BUS_DATA_WIDTH-1:6];
                    rtag_d       = p_bus_reqtag;
                    beat_d       = 3'd0;
                    state_d      = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    state_d = RESPOND;
                end else begin
                    // Evict now so an aborted refill never leaves a half-written line valid.
                    valid_d[idx] = 1'b0;
                    state_d      = MISS_REQ;
                end
            end
            MISS_REQ: begin
                m_bus_reqcyc = 1'b1;
                m_bus_req    = {line_q, 6'b0};
                m_bus_reqtag = rtag_q;
                if (m_bus_reqack) begin
                    state_d = MISS_FILL;
                end
            end
            MISS_FILL: begin
                if (reset && m_bus_respcyc) begin
                    m_bus_respack = 1'b1;
                    fill_we       = 1'b1;
                    beat_d        = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        tag_we       = 1'b1;
                        valid_d[idx] = 1'b1;
                        beat_d       = 3'd0;
                        state_d      = RESPOND;
                    end
                end
            end
            RESPOND: begin
                p_bus_respcyc = 1'b1;
                p_bus_resp    = data_mem[{idx, beat_q}];
                p_bus_resptag = rtag_q;
                if (p_bus_respack) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_direct_mapped_icache.sv
// Directed bench for direct_mapped_icache: cold miss, hits, conflict eviction,
// backpressure on both buses, reset during refill and ignored write requests.
module tb_direct_mapped_icache;

    logic        clk;
    logic        reset;
    logic        p_bus_reqcyc;
    logic [63:0] p_bus_req;
    logic [12:0] p_bus_reqtag;
    logic        p_bus_reqack;
    logic        p_bus_respcyc;
    logic [63:0] p_bus_resp;
    logic [12:0] p_bus_resptag;
    logic        p_bus_respack;
    logic        m_bus_reqcyc;
    logic [63:0] m_bus_req;
    logic [12:0] m_bus_reqtag;
    logic        m_bus_reqack;
    logic        m_bus_respcyc;
    logic [63:0] m_bus_resp;
    logic [12:0] m_bus_resptag;
    logic        m_bus_respack;

    int checks = 0;
    int errors = 0;

    direct_mapped_icache #(
        .BUS_DATA_WIDTH(64),
        .BUS_TAG_WIDTH (13),
        .NUM_SETS      (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .p_bus_reqcyc (p_bus_reqcyc),
        .p_bus_req    (p_bus_req),
        .p_bus_reqtag (p_bus_reqtag),
        .p_bus_reqack (p_bus_reqack),
        .p_bus_respcyc(p_bus_respcyc),
        .p_bus_resp   (p_bus_resp),
        .p_bus_resptag(p_bus_resptag),
        .p_bus_respack(p_bus_respack),
        .m_bus_reqcyc (m_bus_reqcyc),
        .m_bus_req    (m_bus_req),
        .m_bus_reqtag (m_bus_reqtag),
        .m_bus_reqack (m_bus_reqack),
        .m_bus_respcyc(m_bus_respcyc),
        .m_bus_resp   (m_bus_resp),
        .m_bus_resptag(m_bus_resptag),
        .m_bus_respack(m_bus_respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " reqack"}, p_bus_reqack, 0);
        checkOutput({tag, " respcyc"}, p_bus_respcyc, 0);
        checkOutput({tag, " resp"}, p_bus_resp, 0);
        checkOutput({tag, " resptag"}, p_bus_resptag, 0);
        checkOutput({tag, " m_reqcyc"}, m_bus_reqcyc, 0);
        checkOutput({tag, " m_req"}, m_bus_req, 0);
        checkOutput({tag, " m_reqtag"}, m_bus_reqtag, 0);
        checkOutput({tag, " m_respack"}, m_bus_respack, 0);
    endtask

    // Issues a read in the current (IDLE) cycle; returns one cycle later, in LOOKUP.
    task automatic applyStimulus(input logic [63:0] addr, input logic [12:0] tag);
        p_bus_reqcyc = 1'b1;
        p_bus_req    = addr;
        p_bus_reqtag = tag;
        #1;
        checkOutput("req reqack", p_bus_reqack, 1);
        step();
        p_bus_reqcyc = 1'b0;
        #1;
        checkOutput("lookup respcyc", p_bus_respcyc, 0);
        checkOutput("lookup m_reqcyc", m_bus_reqcyc, 0);
    endtask

    // Plays the memory side of a refill, starting from the LOOKUP cycle.
    task automatic serveMiss(input logic [63:0] expAddr, input logic [12:0] expTag,
                             input logic [63:0] base, input int ackDelay,
                             input int gapAfter, input int beats);
        step();
        checkOutput("miss m_reqcyc", m_bus_reqcyc, 1);
        checkOutput("miss m_req", m_bus_req, expAddr);
        checkOutput("miss m_reqtag", m_bus_reqtag, expTag);
        for (int k = 0; k < ackDelay; k++) begin
            step();
            checkOutput("miss hold m_reqcyc", m_bus_reqcyc, 1);
            checkOutput("miss hold m_req", m_bus_req, expAddr);
        end
        m_bus_reqack = 1'b1;
        step();
        m_bus_reqack = 1'b0;
        for (int i = 0; i < beats; i++) begin
            m_bus_respcyc = 1'b1;
            m_bus_resp    = base + 64'(i);
            #1;
            checkOutput("fill respack", m_bus_respack, 1);
            checkOutput("fill no p_respcyc", p_bus_respcyc, 0);
            step();
            if (i == gapAfter) begin
                m_bus_respcyc = 1'b0;
                m_bus_resp    = 64'hDEAD;
                #1;
                checkOutput("fill gap respack", m_bus_respack, 0);
                step();
                step();
            end
        end
        m_bus_respcyc = 1'b0;
        m_bus_resp    = '0;
    endtask

    // Consumes a full line from the processor side, starting in the first RESPOND cycle.
    task automatic readLine(input logic [63:0] base, input logic [12:0] tag,
                            input int stallBeat, input int stallCycles);
        for (int i = 0; i < 8; i++) begin
            p_bus_respack = 1'b0;
            if (i == stallBeat) begin
                for (int k = 0; k < stallCycles; k++) begin
                    checkOutput("stall respcyc", p_bus_respcyc, 1);
                    checkOutput("stall resp", p_bus_resp, base + 64'(i));
                    step();
                end
            end
            p_bus_respack = 1'b1;
            checkOutput("beat respcyc", p_bus_respcyc, 1);
            checkOutput("beat resp", p_bus_resp, base + 64'(i));
            checkOutput("beat resptag", p_bus_resptag, tag);
            checkOutput("beat no m_reqcyc", m_bus_reqcyc, 0);
            step();
        end
        p_bus_respack = 1'b0;
        #1;
        checkOutput("line done respcyc", p_bus_respcyc, 0);
    endtask

    initial begin
        reset         = 1'b0;
        p_bus_reqcyc  = 1'b0;
        p_bus_req     = '0;
        p_bus_reqtag  = '0;
        p_bus_respack = 1'b0;
        m_bus_reqack  = 1'b0;
        m_bus_respcyc = 1'b0;
        m_bus_resp    = '0;
        m_bus_resptag = '0;

        step();
        step();
        checkAllZero("reset");
        reset = 1'b1;
        step();

        $display("[TB] cold miss 0x1000 with delayed memory ack");
        applyStimulus(64'h1000, 13'h1100);
        serveMiss(64'h1000, 13'h1100, 64'hA0, 4, -1, 8);
        readLine(64'hA0, 13'h1100, -1, 0);

        $display("[TB] hit 0x1000 with stall on beat 3, then hit 0x1028");
        applyStimulus(64'h1000, 13'h1101);
        step();
        readLine(64'hA0, 13'h1101, 3, 5);
        applyStimulus(64'h1028, 13'h1102);
        step();
        readLine(64'hA0, 13'h1102, -1, 0);

        $display("[TB] conflict 0x2000 evicts 0x1000");
        applyStimulus(64'h2000, 13'h1200);
        serveMiss(64'h2000, 13'h1200, 64'hB0, 0, 2, 8);
        readLine(64'hB0, 13'h1200, -1, 0);
        applyStimulus(64'h1000, 13'h1103);
        serveMiss(64'h1000, 13'h1103, 64'hC0, 1, -1, 8);
        readLine(64'hC0, 13'h1103, -1, 0);

        $display("[TB] reset after 4 refill beats");
        applyStimulus(64'h3000, 13'h1300);
        serveMiss(64'h3000, 13'h1300, 64'hD0, 0, -1, 4);
        m_bus_respcyc = 1'b1;
        p_bus_reqcyc  = 1'b1;
        p_bus_reqtag  = 13'h1300;
        reset         = 1'b0;
        #1;
        checkAllZero("mid-fill reset");
        step();
        checkAllZero("held reset");
        m_bus_respcyc = 1'b0;
        p_bus_reqcyc  = 1'b0;
        reset         = 1'b1;
        step();
        applyStimulus(64'h3000, 13'h1301);
        serveMiss(64'h3000, 13'h1301, 64'hE0, 0, -1, 8);
        readLine(64'hE0, 13'h1301, -1, 0);

        $display("[TB] write request is never acknowledged");
        p_bus_reqcyc = 1'b1;
        p_bus_req    = 64'h3000;
        p_bus_reqtag = 13'h0100;
        for (int k = 0; k < 10; k++) begin
            #1;
            checkOutput("write reqack", p_bus_reqack, 0);
            checkOutput("write m_reqcyc", m_bus_reqcyc, 0);
            step();
        end
        p_bus_reqcyc = 1'b0;
        applyStimulus(64'h3008, 13'h1302);
        step();
        readLine(64'hE0, 13'h1302, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
